nand_dq_tx: RTL and testbench
=============================

# nand_dq_tx

Source-synchronous NAND data-out transmitter for the controller's program (write) path. It takes a byte stream over a valid/ready handshake and drives the shared DQ/DQS bus toward the flash. Each burst is framed by a DQS preamble and postamble, DQS toggles once per byte, and both output enables are held for the whole burst. It sits beside the PHY capture path and feeds the pad tristate logic that drives `DQ` and `DQS`.

## Interface
Parameters:
- `PRE_CYCLES`, default 2: preamble length in cycles, ≥1.
- `POST_CYCLES`, default 1: postamble length in cycles, ≥1.
- `LEN_W`, default 16: width of `burst_len`.

Ports. One clock; reset is synchronous and active-high.
- `sys_clk` in 1: system clock.
- `sys_rst` in 1: synchronous, active-high reset.
- `start` in 1: begins a burst; sampled only when idle.
- `burst_len` in LEN_W: number of bytes in the burst, latched on an accepted `start`.
- `in_data` in 8: byte to transmit.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the block accepts a byte this cycle.
- `dq_out` out 8: DQ pad output data.
- `dq_oe` out 1: DQ pad output enable.
- `dqs_out` out 1: DQS pad output.
- `dqs_oe` out 1: DQS pad output enable.
- `busy` out 1: a burst is in progress.
- `done` out 1: one-cycle pulse at burst completion.
- `checksum` out 8: present only with `NAND_TX_CHECKSUM_EN`.

## Operation
States: IDLE, PRE, DATA, POST.

- **IDLE**
  - `start`=1 with `burst_len`≠0: latch the length into the remaining-byte counter and go to PRE.
  - `start` with `burst_len`=0: ignored; no `busy`, no `done`.
  - `start` outside IDLE: ignored.
- **PRE**
  - Drive `dq_oe`=`dqs_oe`=1, `dqs_out`=0, `dq_out`=0x00 for `PRE_CYCLES` visible cycles, then go to DATA.
- **DATA**
  - `in_ready` = (state==DATA) && (remaining≠0); combinational from state and counter only, never from `in_valid`.
  - On accept (`in_valid` && `in_ready`): register `dq_out`<=`in_data`, toggle `dqs_out`, decrement remaining.
  - The first byte of every burst is presented with `dqs_out`=1.
  - Stall (no accept): `dq_out` and `dqs_out` hold their values; `oe` stays 1.
  - When remaining reaches 0, go to POST.
- **POST**
  - After the last byte has been visible for one cycle: `dqs_out`=0, `dq_out` holds, `oe`=1, for `POST_CYCLES` cycles.
  - Then IDLE.
- **IDLE outputs**
  - `dq_oe`=`dqs_oe`=0, `dqs_out`=0, `dq_out`=0x00.
- **Counter**
  - LEN_W-bit down-counter.
  - Exactly `burst_len` bytes are accepted; no wrap.
- **Reset**
  - All outputs go to 0 on the next edge: `dq_out`=0x00, `dq_oe`=`dqs_oe`=`dqs_out`=0, `in_ready`=0, `busy`=0, `done`=0, `checksum`=0x00.
  - Reset mid-burst aborts the burst with no `done` pulse.

## Timing
All pad outputs are registered.

- `start` accepted at cycle T.
  - Preamble visible T+1..T+PRE_CYCLES.
  - `in_ready` first high at T+PRE_CYCLES.
- Byte accepted at cycle A is visible on `dq_out` and `dqs_out` at A+1.
- Last byte visible at cycle L.
  - Postamble visible L+1..L+POST_CYCLES.
  - At L+POST_CYCLES+1: `oe`=0, `done`=1 for one cycle, `busy`=0.
- `busy`=1 from T+1 through L+POST_CYCLES.
- The `done` cycle is an IDLE cycle, so `start` in that cycle is accepted for a back-to-back burst.
- With no stalls, burst duration from T to `done` is PRE_CYCLES+N+POST_CYCLES+1 cycles.

## Configuration
`NAND_TX_CHECKSUM_EN`
- **Defined:**
  - `checksum` is the XOR of all bytes accepted in the burst.
  - Cleared on an accepted `start`.
  - Valid at the `done` cycle and held until the next accepted `start`.
- **Undefined:** the `checksum` port and its logic are absent; all other behaviour is identical.

## Test plan
1. **Basic burst.** PRE=2, POST=1; `start` at T with len 4; bytes DE, AD, BE, EF; `in_valid` always high.
   - T+1..T+2: DQS=0.
   - T+3..T+6: DQ = DE/AD/BE/EF with DQS 1/0/1/0.
   - T+7: DQS=0.
   - T+8: `oe`=0, `done`=1, `checksum`=0x22.
2. **Stall.** len 3; `in_valid` low for 2 cycles after the first accept.
   - DQ and DQS hold for 2 cycles; `done` arrives 2 cycles later than the no-stall case.
   - Byte count stays exactly 3.
3. **Ignored starts.**
   - `start` while `busy` → no effect.
   - `start` with len 0 → `busy` stays 0, no `done`.
4. **Reset mid-burst.** `sys_rst` asserted during DATA.
   - Next cycle: `oe`=0, `busy`=0, `in_ready`=0, no `done`.
   - A new len-2 burst then completes normally, with DQS starting at 1.
5. **Odd length.** len 1.
   - DQS=1 on the byte, then 0 in the postamble.
   - `done` at T+5.
6. **Back-to-back.** `start` asserted in the `done` cycle.
   - The second preamble begins the next cycle; the second burst completes with correct data.

Source files
------------

// File: rtl/nand_dq_tx_if.sv
// Byte-stream handshake plus DQ/DQS pad-side outputs of nand_dq_tx.
// master supplies start/length/bytes; slave (the transmitter) returns ready, pad drives and status.
interface nand_dq_tx_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] burst_len;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       dq_out;
    logic             dq_oe;
    logic             dqs_out;
    logic             dqs_oe;
    logic             busy;
    logic             done;

    modport master (
        output start, burst_len, in_data, in_valid,
        input  in_ready, dq_out, dq_oe, dqs_out, dqs_oe, busy, done
    );

    modport slave (
        input  start, burst_len, in_data, in_valid,
        output in_ready, dq_out, dq_oe, dqs_out, dqs_oe, busy, done
    );
endinterface

// File: rtl/nand_dq_tx.sv
// DQ/DQS burst transmitter: registered pads, byte accepted at A shows at A+1; in_ready depends on state/count only.
// Optional NAND_TX_CHECKSUM_EN adds a per-burst XOR checksum output.
module nand_dq_tx #(
    parameter int PRE_CYCLES  = 2,
    parameter int POST_CYCLES = 1,
    parameter int LEN_W       = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
`ifdef NAND_TX_CHECKSUM_EN
    output logic [7:0]  checksum,
`endif
    nand_dq_tx_if.slave bus
);

    localparam int CNT_MAX = (PRE_CYCLES > POST_CYCLES) ? PRE_CYCLES : POST_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    // PRE state lasts PRE_CYCLES-1 cycles; the first DATA cycle still shows preamble on the pads
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_CYCLES - 2);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_POST} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_dq;
    logic             r_dqs;
    logic             r_oe;
    logic             r_done;

    logic             w_start_ok;
    logic             w_in_ready;
    logic             w_accept;
    logic [7:0]       w_dq_nxt;
    logic             w_dqs_nxt;
    logic             w_oe_nxt;
    logic             w_done_nxt;

    assign w_start_ok = (r_state == S_IDLE) && bus.start && (bus.burst_len != '0);
    assign w_in_ready = (r_state == S_DATA) && (r_rem != '0);
    assign w_accept   = w_in_ready && bus.in_valid;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_start_ok) w_state_nxt = (PRE_CYCLES == 1) ? S_DATA : S_PRE;
            S_PRE:  if (r_cnt == PRE_LAST) w_state_nxt = S_DATA;
            S_DATA: if (r_rem == '0) w_state_nxt = S_POST;
            S_POST: if (r_cnt == POST_LAST) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_dq_nxt   = r_dq;
        w_dqs_nxt  = r_dqs;
        w_oe_nxt   = r_oe;
        w_done_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_dq_nxt  = 8'h00;
                w_dqs_nxt = 1'b0;
                w_oe_nxt  = w_start_ok;
            end
            S_PRE: begin
                w_dq_nxt  = 8'h00;
                w_dqs_nxt = 1'b0;
                w_oe_nxt  = 1'b1;
            end
            S_DATA: begin
                // DQS enters DATA low, so the first byte of a burst always toggles it high
                if (w_accept) begin
                    w_dq_nxt  = bus.in_data;
                    w_dqs_nxt = ~r_dqs;
                end else if (r_rem == '0) begin
                    w_dqs_nxt = 1'b0;
                end
            end
            S_POST: begin
                if (w_state_nxt == S_IDLE) begin
                    w_dq_nxt   = 8'h00;
                    w_dqs_nxt  = 1'b0;
                    w_oe_nxt   = 1'b0;
                    w_done_nxt = 1'b1;
                end
            end
            default: begin
                w_dq_nxt  = 8'h00;
                w_dqs_nxt = 1'b0;
                w_oe_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_dq   <= 8'h00;
            r_dqs  <= 1'b0;
            r_oe   <= 1'b0;
            r_done <= 1'b0;
            r_rem  <= '0;
            r_cnt  <= '0;
        end else begin
            r_dq   <= w_dq_nxt;
            r_dqs  <= w_dqs_nxt;
            r_oe   <= w_oe_nxt;
            r_done <= w_done_nxt;
            if (w_start_ok) begin
                r_rem <= bus.burst_len;
            end else if (w_accept) begin
                r_rem <= r_rem - 1'b1;
            end
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_state == S_PRE || r_state == S_POST) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef NAND_TX_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_csum <= 8'h00;
        end else if (w_start_ok) begin
            r_csum <= 8'h00;
        end else if (w_accept) begin
            r_csum <= r_csum ^ bus.in_data;
        end
    end

    assign checksum = r_csum;
`endif

    assign bus.in_ready = w_in_ready;
    assign bus.dq_out   = r_dq;
    assign bus.dq_oe    = r_oe;
    assign bus.dqs_out  = r_dqs;
    assign bus.dqs_oe   = r_oe;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;

endmodule

// File: tb/tb_nand_dq_tx.sv
// Scoreboarded bench for nand_dq_tx with PRE_CYCLES=2, POST_CYCLES=1.
// Cycle k of a burst is the k-th cycle after the one in which start was driven.
module tb_nand_dq_tx;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    nand_dq_tx_if #(.LEN_W(16)) bus ();
`ifdef NAND_TX_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    nand_dq_tx #(.PRE_CYCLES(2), .POST_CYCLES(1), .LEN_W(16)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
`ifdef NAND_TX_CHECKSUM_EN
        .checksum(checksum),
`endif
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [1:0] oe;
        logic       dqs;
        logic [7:0] dq;
        logic       done;
        logic       busy;
        logic       rdy;
    } obs_t;

    obs_t       tr[$];
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic [7:0] pool[$];
    int         t_done;
    int         n_acc;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Drives one burst from pool, records a per-cycle trace, and fills the scoreboard queues.
    task automatic run_burst(input int len, input int stall_at, input int stall_n,
                             input int mid_k, input int budget);
        int   sent;
        int   stalled;
        logic acc_prev;
        logic exp_dqs;
        logic vld;
        obs_t o;
        sent = 0; stalled = 0; acc_prev = 1'b0; exp_dqs = 1'b0;
        tr.delete(); exp_q.delete(); got_q.delete(); t_done = -1;
        bus.start = 1'b1;
        bus.burst_len = 16'(len);
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            o.oe = {bus.dq_oe, bus.dqs_oe}; o.dqs = bus.dqs_out; o.dq = bus.dq_out;
            o.done = bus.done; o.busy = bus.busy; o.rdy = bus.in_ready;
            tr.push_back(o);
            if (acc_prev) got_q.push_back({bus.dqs_out, bus.dq_out});
            if (bus.done) begin
                t_done = k;
                break;
            end
            bus.start     = (k == mid_k);
            bus.burst_len = (k == mid_k) ? 16'd7 : 16'(len);
            vld = (sent < pool.size()) && !(sent == stall_at && stalled < stall_n);
            if (sent == stall_at && stalled < stall_n) stalled++;
            bus.in_valid = vld;
            bus.in_data  = vld ? pool[sent] : 8'h00;
            acc_prev = vld && bus.in_ready;
            if (acc_prev) begin
                exp_dqs = ~exp_dqs;
                exp_q.push_back({exp_dqs, pool[sent]});
                sent++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        n_acc = sent;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.dq_oe, bus.dqs_oe, bus.dqs_out, bus.in_ready, bus.busy, bus.done, bus.dq_out} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0", {bus.dq_oe, bus.dqs_oe, bus.dqs_out,
                     bus.in_ready, bus.busy, bus.done, bus.dq_out});
        end
`ifdef NAND_TX_CHECKSUM_EN
        checks++;
        if (checksum !== 8'h00) begin
            errors++;
            $display("FAIL reset_checksum got=%h exp=00", checksum);
        end
`endif
        sys_rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] dat_tab [4];
        logic       dqs_tab [4];
        logic [8:0] e;
        logic [8:0] g;
        dat_tab = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        dqs_tab = '{1'b1, 1'b0, 1'b1, 1'b0};
        pool = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_burst(4, -1, 0, 0, 40);
        checks++;
        if (t_done !== 8) begin
            errors++;
            $display("FAIL basic_done_cycle got=%0d exp=8", t_done);
        end
        for (int k = 1; k <= 2; k++) begin
            checks++;
            if ({tr[k-1].oe, tr[k-1].dqs, tr[k-1].dq, tr[k-1].busy} !== {2'b11, 1'b0, 8'h00, 1'b1}) begin
                errors++;
                $display("FAIL basic_preamble k=%0d got=%h exp=%h", k,
                         {tr[k-1].oe, tr[k-1].dqs, tr[k-1].dq, tr[k-1].busy}, {2'b11, 1'b0, 8'h00, 1'b1});
            end
        end
        checks++;
        if ({tr[0].rdy, tr[1].rdy} !== 2'b01) begin
            errors++;
            $display("FAIL basic_first_ready got=%b exp=01", {tr[0].rdy, tr[1].rdy});
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({tr[i+2].oe, tr[i+2].dqs, tr[i+2].dq} !== {2'b11, dqs_tab[i], dat_tab[i]}) begin
                errors++;
                $display("FAIL basic_data k=%0d got=%h exp=%h", i + 3,
                         {tr[i+2].oe, tr[i+2].dqs, tr[i+2].dq}, {2'b11, dqs_tab[i], dat_tab[i]});
            end
        end
        checks++;
        if ({tr[6].oe, tr[6].dqs, tr[6].dq, tr[6].busy} !== {2'b11, 1'b0, 8'hEF, 1'b1}) begin
            errors++;
            $display("FAIL basic_postamble got=%h exp=%h", {tr[6].oe, tr[6].dqs, tr[6].dq, tr[6].busy},
                     {2'b11, 1'b0, 8'hEF, 1'b1});
        end
        checks++;
        if ({tr[7].oe, tr[7].dqs, tr[7].dq, tr[7].done, tr[7].busy} !== {2'b00, 1'b0, 8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL basic_done_state got=%h exp=%h",
                     {tr[7].oe, tr[7].dqs, tr[7].dq, tr[7].done, tr[7].busy}, {2'b00, 1'b0, 8'h00, 1'b1, 1'b0});
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++;
                $display("FAIL basic_sb_missing got=none exp=%h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL basic_sb got=%h exp=%h", g, e);
                end
            end
        end
`ifdef NAND_TX_CHECKSUM_EN
        checks++;
        if (checksum !== 8'h22) begin
            errors++;
            $display("FAIL basic_checksum got=%h exp=22", checksum);
        end
`endif
        tick();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width got=%b exp=0", bus.done);
        end
    endtask

    task automatic test_stall();
        logic [8:0] e;
        logic [8:0] g;
        pool = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_burst(3, 1, 2, 0, 40);
        checks++;
        if (t_done !== 9) begin
            errors++;
            $display("FAIL stall_done_cycle got=%0d exp=9", t_done);
        end
        checks++;
        if (n_acc !== 3) begin
            errors++;
            $display("FAIL stall_byte_count got=%0d exp=3", n_acc);
        end
        for (int k = 4; k <= 5; k++) begin
            checks++;
            if ({tr[k-1].oe, tr[k-1].dqs, tr[k-1].dq} !== {2'b11, 1'b1, 8'h11}) begin
                errors++;
                $display("FAIL stall_hold k=%0d got=%h exp=%h", k, {tr[k-1].oe, tr[k-1].dqs, tr[k-1].dq},
                         {2'b11, 1'b1, 8'h11});
            end
        end
        checks++;
        if ({tr[6].dqs, tr[6].dq, tr[6].rdy} !== {1'b1, 8'h33, 1'b0}) begin
            errors++;
            $display("FAIL stall_last got=%h exp=%h", {tr[6].dqs, tr[6].dq, tr[6].rdy}, {1'b1, 8'h33, 1'b0});
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++;
                $display("FAIL stall_sb_missing got=none exp=%h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL stall_sb got=%h exp=%h", g, e);
                end
            end
        end
    endtask

    task automatic test_ignored_start();
        int seen;
        pool = '{8'h5A, 8'hA5, 8'h99};
        run_burst(2, -1, 0, 3, 40);
        checks++;
        if ({t_done, n_acc} !== {32'd6, 32'd2}) begin
            errors++;
            $display("FAIL busy_start_ignored got=done%0d/bytes%0d exp=done6/bytes2", t_done, n_acc);
        end
        bus.start = 1'b1;
        bus.burst_len = 16'd0;
        tick();
        bus.start = 1'b0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.busy || bus.done || bus.dq_oe) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL zero_len_start got=%0d active cycles exp=0", seen);
        end
    endtask

    task automatic test_reset_mid_burst();
        int         seen;
        logic [8:0] e;
        logic [8:0] g;
        pool = '{8'hF0, 8'hF1, 8'hF2, 8'hF3};
        run_burst(4, -1, 0, 0, 4);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        checks++;
        if ({bus.dq_oe, bus.dqs_oe, bus.dqs_out, bus.busy, bus.in_ready, bus.done, bus.dq_out} !== 14'h0) begin
            errors++;
            $display("FAIL midrst_outputs got=%b exp=0", {bus.dq_oe, bus.dqs_oe, bus.dqs_out, bus.busy,
                     bus.in_ready, bus.done, bus.dq_out});
        end
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.done || bus.busy) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midrst_no_done got=%0d exp=0", seen);
        end
        pool = '{8'hC3, 8'h3C, 8'h55};
        run_burst(2, -1, 0, 0, 40);
        checks++;
        if ({t_done, n_acc} !== {32'd6, 32'd2}) begin
            errors++;
            $display("FAIL midrst_rerun got=done%0d/bytes%0d exp=done6/bytes2", t_done, n_acc);
        end
        checks++;
        if ({tr[2].dqs, tr[2].dq, tr[3].dqs, tr[3].dq} !== {1'b1, 8'hC3, 1'b0, 8'h3C}) begin
            errors++;
            $display("FAIL midrst_rerun_data got=%h exp=%h", {tr[2].dqs, tr[2].dq, tr[3].dqs, tr[3].dq},
                     {1'b1, 8'hC3, 1'b0, 8'h3C});
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++;
                $display("FAIL midrst_sb_missing got=none exp=%h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL midrst_sb got=%h exp=%h", g, e);
                end
            end
        end
    endtask

    task automatic test_odd_length();
        pool = '{8'h77, 8'h88};
        run_burst(1, -1, 0, 0, 40);
        checks++;
        if ({t_done, n_acc} !== {32'd5, 32'd1}) begin
            errors++;
            $display("FAIL odd_done got=done%0d/bytes%0d exp=done5/bytes1", t_done, n_acc);
        end
        checks++;
        if ({tr[2].oe, tr[2].dqs, tr[2].dq, tr[3].oe, tr[3].dqs, tr[3].dq}
            !== {2'b11, 1'b1, 8'h77, 2'b11, 1'b0, 8'h77}) begin
            errors++;
            $display("FAIL odd_dqs got=%h exp=%h", {tr[2].oe, tr[2].dqs, tr[2].dq, tr[3].oe, tr[3].dqs, tr[3].dq},
                     {2'b11, 1'b1, 8'h77, 2'b11, 1'b0, 8'h77});
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] e;
        logic [8:0] g;
        logic [7:0] csum;
        pool = '{8'hA1, 8'hA2};
        run_burst(2, -1, 0, 0, 40);
        checks++;
        if (t_done !== 6) begin
            errors++;
            $display("FAIL b2b_first_done got=%0d exp=6", t_done);
        end
        pool = '{8'hB1, 8'hB2, 8'hB3};
        csum = 8'h00;
        foreach (pool[i]) csum ^= pool[i];
        run_burst(3, -1, 0, 0, 40);
        checks++;
        if ({tr[0].oe, tr[0].dqs, tr[0].dq, tr[0].busy, tr[0].done} !== {2'b11, 1'b0, 8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_preamble got=%h exp=%h", {tr[0].oe, tr[0].dqs, tr[0].dq, tr[0].busy, tr[0].done},
                     {2'b11, 1'b0, 8'h00, 1'b1, 1'b0});
        end
        checks++;
        if ({t_done, n_acc} !== {32'd7, 32'd3}) begin
            errors++;
            $display("FAIL b2b_second_done got=done%0d/bytes%0d exp=done7/bytes3", t_done, n_acc);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++;
                $display("FAIL b2b_sb_missing got=none exp=%h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL b2b_sb got=%h exp=%h", g, e);
                end
            end
        end
`ifdef NAND_TX_CHECKSUM_EN
        checks++;
        if (checksum !== csum) begin
            errors++;
            $display("FAIL b2b_checksum got=%h exp=%h", checksum, csum);
        end
`endif
        tick();
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.burst_len = 16'd0;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_ignored_start();
        test_reset_mid_burst();
        test_odd_length();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
